// File: rtl/column_drain_scheduler.sv
// Column drain scheduler: resets the column units, waits for them to finish, then drains column FIFOs 0..7 in order to a ready/valid consumer.
// Optional GEN-state watchdog enabled by defining COLARB_TIMEOUT_EN.
module column_drain_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    col_done,
    input  logic [7:0]    col_empty,
    input  logic [1215:0] col_data,
    output logic [7:0]    col_rden,
    output logic          col_reset,
    output logic [151:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [9:0]    move_count,
    output logic          timeout
);

    typedef enum logic [2:0] {IDLE, CLR, GEN, RDREQ, CAPT, HOLD, FIN} state_t;

    state_t         state_reg;
    logic [2:0]     ptr_reg;
    logic [151:0]   out_data_reg;
    logic           out_valid_reg;
    logic [9:0]     move_count_reg;
    logic [151:0]   col_slice [8];

`ifdef COLARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  gen_cnt_reg;
    logic           timeout_reg;
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    // Read enable is a pure decode so it can only ever be high for the column under the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign col_slice[gi] = col_data[152*gi +: 152];
            assign col_rden[gi]  = (state_reg == RDREQ) && (ptr_reg == 3'(gi)) && !col_empty[gi];
        end
    endgenerate

    assign col_reset  = reset || (state_reg == CLR);
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign move_count = move_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= 3'd0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            move_count_reg <= 10'd0;
`ifdef COLARB_TIMEOUT_EN
            gen_cnt_reg    <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= CLR;
                        move_count_reg <= 10'd0;
`ifdef COLARB_TIMEOUT_EN
                        timeout_reg    <= 1'b0;
`endif
                    end
                end
                CLR: begin
                    state_reg <= GEN;
`ifdef COLARB_TIMEOUT_EN
                    gen_cnt_reg <= '0;
`endif
                end
                GEN: begin
                    if (col_done == 8'hFF) begin
                        state_reg <= RDREQ;
                        ptr_reg   <= 3'd0;
                    end
`ifdef COLARB_TIMEOUT_EN
                    else if (gen_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= FIN;
                    end else begin
                        gen_cnt_reg <= gen_cnt_reg + 1'b1;
                    end
`endif
                end
                RDREQ: begin
                    if (!col_empty[ptr_reg]) begin
                        state_reg <= CAPT;
                    end else if (ptr_reg != 3'd7) begin
                        ptr_reg <= ptr_reg + 3'd1;
                    end else begin
                        state_reg <= FIN;
                    end
                end
                CAPT: begin
                    // FIFO read data is valid the cycle after the read enable.
                    out_data_reg  <= col_slice[ptr_reg];
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (move_count_reg != 10'd1023) begin
                            move_count_reg <= move_count_reg + 10'd1;
                        end
                        state_reg <= RDREQ;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_drain_scheduler.sv
// Bench for column_drain_scheduler: behavioural column FIFOs, randomized plans and consumer back-pressure,
// expected output order computed as the in-order concatenation of every column's planned words.
module tb_column_drain_scheduler;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    col_done;
    logic [7:0]    col_empty;
    logic [1215:0] col_data;
    logic [7:0]    col_rden;
    logic          col_reset;
    logic [151:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [9:0]    move_count;
    logic          timeout;

    always #5 clk = ~clk;

    column_drain_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .col_done(col_done),
        .col_empty(col_empty), .col_data(col_data), .col_rden(col_rden),
        .col_reset(col_reset), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done),
        .move_count(move_count), .timeout(timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pass plan: words each column produces after its reset, and how long generation takes.
    int           plan_n [8];
    logic [151:0] plan_w [8][256];
    logic [7:0]   done_mask;
    int           gen_delay;
    int           ready_mode;

    // Column unit model: cleared by col_reset, publishes its words and done after gen_delay cycles.
    int           avail [8];
    int           rd_idx [8];
    logic [151:0] rd_data [8];
    int           gen_timer;
    logic         gen_active = 1'b0;

    always @(posedge clk) begin
        if (col_reset) begin
            for (int i = 0; i < 8; i++) begin
                avail[i]  <= 0;
                rd_idx[i] <= 0;
            end
            col_done   <= 8'h00;
            gen_timer  <= gen_delay;
            gen_active <= 1'b1;
        end else begin
            if (gen_active) begin
                if (gen_timer == 0) begin
                    for (int i = 0; i < 8; i++) avail[i] <= plan_n[i];
                    col_done   <= done_mask;
                    gen_active <= 1'b0;
                end else begin
                    gen_timer <= gen_timer - 1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (col_rden[i] && rd_idx[i] < avail[i]) begin
                    rd_data[i] <= plan_w[i][rd_idx[i]];
                    rd_idx[i]  <= rd_idx[i] + 1;
                end
            end
        end
    end

    always_comb begin
        col_empty = 8'h00;
        col_data  = '0;
        for (int i = 0; i < 8; i++) begin
            col_empty[i] = !(rd_idx[i] < avail[i]);
            col_data[152*i +: 152] = rd_data[i];
        end
    end

    always @(posedge clk) begin
        case (ready_mode)
            0:       out_ready <= 1'b1;
            1:       out_ready <= 1'($urandom_range(0, 1));
            default: out_ready <= 1'b0;
        endcase
    end

    // Protocol monitor, sampled on the falling edge.
    int           rden_cnt [8];
    int           done_cnt, colrst_cyc, viol, got_n, busy_other;
    logic [151:0] got_w [2048];
    logic         prev_valid, prev_ready;
    logic [151:0] prev_data;

    initial begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if ($countones(col_rden) > 1) viol++;
            if (col_rden != 8'h00 && out_valid) viol++;
            if ((col_rden & col_empty) != 8'h00) viol++;
            for (int i = 0; i < 8; i++) if (col_rden[i]) rden_cnt[i]++;
            if (col_reset && !reset) colrst_cyc++;
            if (done) done_cnt++;
            if (busy && !col_reset && !done) busy_other++;
            if (prev_valid && !prev_ready && !reset) begin
                if (!out_valid || out_data !== prev_data) viol++;
            end
            if (out_valid && out_ready && got_n < 2048) begin
                got_w[got_n] = out_data;
                got_n++;
            end
            prev_valid = out_valid && !reset;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    function automatic logic [151:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[151:0];
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) plan_n[i] = 0;
    endtask

    task automatic fill_col(input int c, input int n);
        plan_n[c] = n;
        for (int k = 0; k < n; k++) plan_w[c][k] = rand_word();
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) rden_cnt[i] = 0;
        done_cnt = 0; colrst_cyc = 0; viol = 0; got_n = 0; busy_other = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait_done"}, done, 1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait_valid"}, out_valid, 1);
    endtask

    task automatic final_checks(input string name);
        int total = 0;
        int mism = 0;
        logic [7:0] rden_ok;
        logic [151:0] exp_w [2048];
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < plan_n[c]; k++) begin
                exp_w[total] = plan_w[c][k];
                total++;
            end
            rden_ok[c] = (rden_cnt[c] == plan_n[c]);
        end
        for (int k = 0; k < total && k < got_n; k++) if (got_w[k] !== exp_w[k]) mism++;
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_col_reset_cycles"}, colrst_cyc, 1);
        check({name, "_words"}, got_n, total);
        check({name, "_order"}, mism, 0);
        check({name, "_rden_per_col"}, rden_ok, 8'hFF);
        check({name, "_move_count"}, move_count, (total > 1023) ? 1023 : total);
        check({name, "_protocol"}, viol, 0);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_timeout"}, timeout, 0);
    endtask

    task automatic run_pass(input string name, input bit second_start);
        clear_mon();
        pulse_start();
        if (second_start) begin
            repeat (2) @(negedge clk);
            pulse_start();
        end
        wait_done(name, 20000);
        final_checks(name);
    endtask

    initial begin
        logic [151:0] hd;
        int cnt;
        reset = 1'b1; start = 1'b0; ready_mode = 0; done_mask = 8'hFF; gen_delay = 1;
        clear_plan();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_move_count", move_count, 0);
        check("rst_timeout", timeout, 0);
        check("rst_col_rden", col_rden, 0);
        check("rst_col_reset", col_reset, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_col_reset", col_reset, 0);

        run_pass("empty", 0);

        clear_plan();
        fill_col(2, 3);
        fill_col(5, 1);
        run_pass("c2c5", 0);

        // Back-pressure: first word must sit stable while the consumer stalls.
        clear_plan();
        fill_col(0, 2);
        ready_mode = 2;
        clear_mon();
        pulse_start();
        wait_valid("hold", 100);
        hd = out_data;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid && out_data === hd) cnt++;
        end
        @(posedge clk);
        #1;
        check("hold_stable_cycles", cnt, 10);
        check("hold_word", hd, plan_w[0][0]);
        check("hold_single_read", rden_cnt[0], 1);
        ready_mode = 0;
        wait_done("hold", 200);
        final_checks("hold");

        // Reset while a word is being held.
        clear_plan();
        fill_col(3, 2);
        ready_mode = 2;
        clear_mon();
        pulse_start();
        wait_valid("midrst", 100);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_move_count", move_count, 0);
        ready_mode = 0;
        run_pass("after_rst", 0);

        clear_plan();
        fill_col(1, 2);
        fill_col(6, 3);
        gen_delay = 8;
        run_pass("restart", 1);

        for (int r = 0; r < 4; r++) begin
            clear_plan();
            for (int c = 0; c < 8; c++) if ($urandom_range(0, 1) != 0) fill_col(c, $urandom_range(1, 4));
            gen_delay = $urandom_range(1, 8);
            ready_mode = $urandom_range(0, 1);
            run_pass($sformatf("rnd%0d", r), 0);
        end

        clear_plan();
        for (int c = 0; c < 8; c++) fill_col(c, 130);
        gen_delay = 2;
        ready_mode = 0;
        run_pass("saturate", 0);

        clear_plan();
        gen_delay = 1;
        done_mask = 8'h7F;
`ifdef COLARB_TIMEOUT_EN
        clear_mon();
        pulse_start();
        wait_done("to", 200);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check("to_flag", timeout, 1);
        check("to_done_pulses", done_cnt, 1);
        check("to_gen_cycles", busy_other, 16);
        check("to_move_count", move_count, 0);
        done_mask = 8'hFF;
        run_pass("after_to", 0);
`else
        clear_mon();
        pulse_start();
        repeat (200) @(posedge clk);
        #1;
        check("hang_busy", busy, 1);
        check("hang_timeout", timeout, 0);
        check("hang_no_done", done_cnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        done_mask = 8'hFF;
        run_pass("after_hang", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
